// File: rtl/uart_boot_loader.sv
// Serial boot loader: programs the uart divider, receives a length-prefixed image,
// packs it into little-endian words for RAM, then answers with ACK or NAK.
module uart_boot_loader #(
  parameter logic [31:0] UART_BASE = 32'h0000_0000,
  parameter logic [15:0] CLK_DIV   = 16'd104,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MAX_BYTES = 32'd65536
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] address_out,
  output logic        sel_out,
  output logic        read_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in,
  output logic [31:0] mem_address_out,
  output logic        mem_sel_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic        mem_ready_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out
);

  typedef enum logic [2:0] {
    S_INIT, S_RX_POLL, S_RX_READ, S_MEM_WR, S_TX_POLL, S_TX_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] REG_STATUS = UART_BASE + 32'd4;
  localparam logic [31:0] REG_DATA   = UART_BASE + 32'd8;

  state_t      state, next_state;
  logic [31:0] byte_count;
  logic [31:0] len_word;
  logic [31:0] shift_word;
  logic [31:0] word_index;
  logic        in_payload;
  logic        nak;

  logic [1:0]  lane;
  logic [31:0] merged;
  logic [31:0] count_next;
  logic        unused_read_bits;

  // byte_count has already advanced past the last byte when MEM_WR runs
  function automatic logic [3:0] tail_mask(input logic [1:0] filled);
    case (filled)
      2'd1:    tail_mask = 4'b0001;
      2'd2:    tail_mask = 4'b0011;
      2'd3:    tail_mask = 4'b0111;
      default: tail_mask = 4'b1111;
    endcase
  endfunction

  assign lane             = byte_count[1:0];
  assign merged           = shift_word | ({24'b0, read_value_in[7:0]} << {lane, 3'b000});
  assign count_next       = byte_count + 32'd1;
  assign unused_read_bits = ^read_value_in[31:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state          = state;
    sel_out             = 1'b0;
    address_out         = 32'b0;
    read_out            = 1'b0;
    write_mask_out      = 4'b0;
    write_value_out     = 32'b0;
    mem_sel_out         = 1'b0;
    mem_address_out     = 32'b0;
    mem_write_mask_out  = 4'b0;
    mem_write_value_out = 32'b0;
    busy_out            = 1'b1;
    done_out            = 1'b0;
    error_out           = 1'b0;
    case (state)
      S_INIT: begin
        sel_out         = 1'b1;
        address_out     = UART_BASE;
        write_mask_out  = 4'b0011;
        write_value_out = {16'b0, CLK_DIV};
        if (ready_in) next_state = S_RX_POLL;
      end
      S_RX_POLL: begin
        sel_out     = 1'b1;
        address_out = REG_STATUS;
        read_out    = 1'b1;
        if (ready_in && read_value_in[1]) next_state = S_RX_READ;
      end
      S_RX_READ: begin
        sel_out     = 1'b1;
        address_out = REG_DATA;
        read_out    = 1'b1;
        if (ready_in) begin
          if (!in_payload) begin
            if (lane == 2'd3 && (merged == 32'd0 || merged > MAX_BYTES))
              next_state = S_TX_POLL;
            else
              next_state = S_RX_POLL;
          end else if (lane == 2'd3 || count_next == len_word) begin
            next_state = S_MEM_WR;
          end else begin
            next_state = S_RX_POLL;
          end
        end
      end
      S_MEM_WR: begin
        mem_sel_out         = 1'b1;
        mem_address_out     = MEM_BASE + (word_index << 2);
        mem_write_mask_out  = tail_mask(byte_count[1:0]);
        mem_write_value_out = shift_word;
        if (mem_ready_in) next_state = (byte_count == len_word) ? S_TX_POLL : S_RX_POLL;
      end
      S_TX_POLL: begin
        sel_out     = 1'b1;
        address_out = REG_STATUS;
        read_out    = 1'b1;
        if (ready_in && read_value_in[0]) next_state = S_TX_WRITE;
      end
      S_TX_WRITE: begin
        sel_out         = 1'b1;
        address_out     = REG_DATA;
        write_mask_out  = 4'b0001;
        write_value_out = {24'b0, (nak ? 8'h15 : 8'h06)};
        if (ready_in) next_state = nak ? S_ERROR : S_DONE;
      end
      S_DONE: begin
        busy_out = 1'b0;
        done_out = 1'b1;
      end
      default: begin
        busy_out  = 1'b0;
        error_out = 1'b1;
      end
    endcase
    // reset must release both buses without waiting for a clock edge
    if (reset) begin
      sel_out             = 1'b0;
      address_out         = 32'b0;
      read_out            = 1'b0;
      write_mask_out      = 4'b0;
      write_value_out     = 32'b0;
      mem_sel_out         = 1'b0;
      mem_address_out     = 32'b0;
      mem_write_mask_out  = 4'b0;
      mem_write_value_out = 32'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_count <= 32'b0;
      len_word   <= 32'b0;
      shift_word <= 32'b0;
      word_index <= 32'b0;
      in_payload <= 1'b0;
      nak        <= 1'b0;
    end else begin
      if (state == S_RX_READ && ready_in) begin
        if (!in_payload && lane == 2'd3) begin
          len_word   <= merged;
          shift_word <= 32'b0;
          byte_count <= 32'b0;
          if (merged > MAX_BYTES)    nak        <= 1'b1;
          else if (merged != 32'd0)  in_payload <= 1'b1;
        end else begin
          shift_word <= merged;
          byte_count <= count_next;
        end
      end
      if (state == S_MEM_WR && mem_ready_in) begin
        word_index <= word_index + 32'd1;
        shift_word <= 32'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: uart and RAM slave models with random latency,
// table vectors, randomized images against a byte-level model, and reset/stall sequences.
module tb_uart_boot_loader;

  localparam logic [31:0] UB   = 32'h4000_0000;
  localparam logic [31:0] MB   = 32'h2000_0100;
  localparam logic [31:0] MAXB = 32'd65536;

  logic        clk, reset;
  logic [31:0] address_out, read_value_in, write_value_out;
  logic        sel_out, read_out, ready_in;
  logic [3:0]  write_mask_out;
  logic [31:0] mem_address_out, mem_write_value_out;
  logic        mem_sel_out, mem_ready_in;
  logic [3:0]  mem_write_mask_out;
  logic        busy_out, done_out, error_out;

  uart_boot_loader #(.UART_BASE(UB), .CLK_DIV(16'd104), .MEM_BASE(MB), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .reset(reset),
    .address_out(address_out), .sel_out(sel_out), .read_out(read_out),
    .read_value_in(read_value_in), .write_mask_out(write_mask_out),
    .write_value_out(write_value_out), .ready_in(ready_in),
    .mem_address_out(mem_address_out), .mem_sel_out(mem_sel_out),
    .mem_write_mask_out(mem_write_mask_out), .mem_write_value_out(mem_write_value_out),
    .mem_ready_in(mem_ready_in),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] len;
    int          npay;
    logic [63:0] pay;
    logic [7:0]  exp_tx;
    int          exp_words;
    logic [31:0] exp_w0;
    logic [3:0]  exp_mlast;
    logic [31:0] exp_wlast;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  wr_t        uart_log[$];
  wr_t        mem_log[$];
  logic [7:0] rxq[$];
  int         checks = 0;
  int         errors = 0;
  int         proto_err = 0;
  int         m_unstable = 0;
  int         m_force = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // uart slave: status/data registers backed by rxq, writes logged
  logic [31:0] u_addr, u_val;
  logic        u_rd;
  logic [3:0]  u_mask;
  int          u_wait;
  bit          u_busy;
  initial begin
    logic [31:0] rv;
    ready_in = 1'b0; read_value_in = 32'b0; u_busy = 0; u_wait = 0;
    forever begin
      @(negedge clk);
      if (!sel_out && (address_out != 0 || read_out || write_mask_out != 0 || write_value_out != 0))
        proto_err++;
      if (sel_out && read_out && write_mask_out != 0) proto_err++;
      if (reset) begin
        ready_in = 1'b0; u_busy = 0;
      end else if (ready_in) begin
        ready_in = 1'b0; u_busy = 0;
        if (u_rd) begin
          if (u_addr == UB + 32'd8) begin
            if (rxq.size() > 0) void'(rxq.pop_front());
            else proto_err++;
          end
        end else begin
          uart_log.push_back('{u_addr, u_mask, u_val});
        end
      end else if (sel_out) begin
        if (!u_busy) begin
          u_busy = 1; u_addr = address_out; u_rd = read_out;
          u_mask = write_mask_out; u_val = write_value_out;
          u_wait = $urandom_range(0, 2);
        end else if ({address_out, read_out, write_mask_out, write_value_out} !=
                     {u_addr, u_rd, u_mask, u_val}) begin
          proto_err++;
        end
        if (u_wait == 0) begin
          rv = $urandom;
          if (u_addr == UB + 32'd4) begin
            rv[1] = (rxq.size() > 0) && ($urandom_range(0, 3) != 0);
            rv[0] = ($urandom_range(0, 2) != 0);
          end else if (u_addr == UB + 32'd8) begin
            rv[7:0] = (rxq.size() > 0) ? rxq[0] : 8'h00;
          end
          read_value_in = rv;
          ready_in = 1'b1;
        end else begin
          u_wait--;
        end
      end
    end
  end

  // RAM slave: logs completed writes, optional forced stall, flags field changes while stalled
  wr_t m_snap;
  int  m_wait;
  bit  m_busy;
  initial begin
    mem_ready_in = 1'b0; m_busy = 0; m_wait = 0;
    forever begin
      @(negedge clk);
      if (!mem_sel_out && (mem_address_out != 0 || mem_write_mask_out != 0 || mem_write_value_out != 0))
        proto_err++;
      if (reset) begin
        mem_ready_in = 1'b0; m_busy = 0;
      end else if (mem_ready_in) begin
        mem_ready_in = 1'b0; m_busy = 0;
        mem_log.push_back(m_snap);
      end else if (mem_sel_out) begin
        if (!m_busy) begin
          m_busy = 1;
          m_snap = '{mem_address_out, mem_write_mask_out, mem_write_value_out};
          m_wait = (m_force > 0) ? m_force : $urandom_range(0, 2);
          m_force = 0;
        end else if ({mem_address_out, mem_write_mask_out, mem_write_value_out} != m_snap) begin
          m_unstable++;
        end
        if (m_wait == 0) mem_ready_in = 1'b1;
        else m_wait--;
      end
    end
  end

  task automatic start_image(input logic [7:0] img[$]);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    uart_log.delete(); mem_log.delete(); rxq = img;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit fin = 0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      fin = done_out || error_out;
    end
    chk({tag, "/terminate"}, fin, 1);
    repeat (3) @(negedge clk);
  endtask

  // reference: derive every expected bus write straight from the image bytes
  task automatic check_model(input logic [7:0] img[$], input string tag);
    logic [31:0] len, data;
    logic [3:0]  mask;
    int          nwords, idx;
    bit          nakx;
    len    = {img[3], img[2], img[1], img[0]};
    nakx   = (len > MAXB);
    nwords = (len == 0 || nakx) ? 0 : int'((len + 32'd3) / 32'd4);
    chk({tag, "/mem_n"}, mem_log.size(), nwords);
    for (int w = 0; w < nwords && w < mem_log.size(); w++) begin
      data = 32'b0; mask = 4'b0;
      for (int k = 0; k < 4; k++) begin
        idx = 4 * w + k;
        if (idx < int'(len)) begin
          data = data | ({24'b0, img[4 + idx]} << (8 * k));
          mask[k] = 1'b1;
        end
      end
      chk({tag, "/mem_addr"}, mem_log[w].addr, MB + 32'(4 * w));
      chk({tag, "/mem_mask"}, mem_log[w].mask, mask);
      chk({tag, "/mem_data"}, mem_log[w].data, data);
    end
    chk({tag, "/uart_n"}, uart_log.size(), 2);
    if (uart_log.size() >= 1) chk({tag, "/div_wr"}, uart_log[0], {UB, 4'b0011, 32'h0000_0068});
    if (uart_log.size() >= 2)
      chk({tag, "/tx_wr"}, uart_log[1], {UB + 32'd8, 4'b0001, 24'b0, (nakx ? 8'h15 : 8'h06)});
    chk({tag, "/done"}, done_out, !nakx);
    chk({tag, "/error"}, error_out, nakx);
    chk({tag, "/busy"}, busy_out, 0);
  endtask

  initial begin
    vec_t        vecs[7];
    logic [7:0]  img[$];
    logic [31:0] len;
    int          n;
    bit          got;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst/busy", busy_out, 1);
    chk("rst/done", done_out, 0);
    chk("rst/error", error_out, 0);
    chk("rst/sel", {sel_out, read_out, write_mask_out, address_out}, 0);
    chk("rst/mem_sel", {mem_sel_out, mem_write_mask_out, mem_address_out}, 0);

    vecs[0] = '{32'd4, 4, 64'h0000_0000_EFBE_ADDE, 8'h06, 1, 32'hEFBEADDE, 4'b1111, 32'hEFBEADDE, 1'b1, 1'b0};
    vecs[1] = '{32'd5, 5, 64'h0000_0055_4433_2211, 8'h06, 2, 32'h44332211, 4'b0001, 32'h00000055, 1'b1, 1'b0};
    vecs[2] = '{32'd0, 0, 64'h0, 8'h06, 0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{32'd65537, 0, 64'h0, 8'h15, 0, 32'h0, 4'b0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{32'd6, 6, 64'h0000_0605_0403_0201, 8'h06, 2, 32'h04030201, 4'b0011, 32'h00000605, 1'b1, 1'b0};
    vecs[5] = '{32'd3, 3, 64'h0000_0000_00CC_BBAA, 8'h06, 1, 32'h00CCBBAA, 4'b0111, 32'h00CCBBAA, 1'b1, 1'b0};
    vecs[6] = '{32'd8, 8, 64'h1716_1514_1312_1110, 8'h06, 2, 32'h13121110, 4'b1111, 32'h17161514, 1'b1, 1'b0};

    for (int v = 0; v < 7; v++) begin
      img.delete();
      for (int k = 0; k < 4; k++) img.push_back(vecs[v].len[8 * k +: 8]);
      for (int k = 0; k < vecs[v].npay; k++) img.push_back(vecs[v].pay[8 * k +: 8]);
      start_image(img);
      wait_end($sformatf("vec%0d", v));
      chk($sformatf("vec%0d/words", v), mem_log.size(), vecs[v].exp_words);
      if (uart_log.size() >= 2) chk($sformatf("vec%0d/tx", v), uart_log[1].data[7:0], vecs[v].exp_tx);
      if (vecs[v].exp_words > 0 && mem_log.size() == vecs[v].exp_words) begin
        chk($sformatf("vec%0d/w0", v), mem_log[0].data, vecs[v].exp_w0);
        chk($sformatf("vec%0d/wlast", v), mem_log[vecs[v].exp_words - 1].data, vecs[v].exp_wlast);
        chk($sformatf("vec%0d/mlast", v), mem_log[vecs[v].exp_words - 1].mask, vecs[v].exp_mlast);
      end
      chk($sformatf("vec%0d/done", v), done_out, vecs[v].exp_done);
      chk($sformatf("vec%0d/error", v), error_out, vecs[v].exp_err);
      check_model(img, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      img.delete();
      len = 32'($urandom_range(1, 14));
      for (int k = 0; k < 4; k++) img.push_back(len[8 * k +: 8]);
      for (int k = 0; k < int'(len); k++) img.push_back(8'($urandom));
      start_image(img);
      wait_end($sformatf("rnd%0d", r));
      check_model(img, $sformatf("rnd%0d", r));
    end

    // LEN == MAX_BYTES is accepted: payload words land in RAM, no NAK
    img.delete();
    img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h01); img.push_back(8'h00);
    for (int k = 0; k < 8; k++) img.push_back(8'(8'hA0 + k));
    start_image(img);
    got = 0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clk);
      got = (mem_log.size() >= 2);
    end
    chk("max/words_seen", got, 1);
    repeat (20) @(negedge clk);
    if (mem_log.size() >= 2) chk("max/w1", mem_log[1], {MB + 32'd4, 4'b1111, 32'hA7A6A5A4});
    chk("max/uart_n", uart_log.size(), 1);
    chk("max/state", {busy_out, done_out, error_out}, 3'b100);

    // RAM stall during the first word, then reset while stalled
    img.delete();
    img.push_back(8'h08); img.push_back(8'h00); img.push_back(8'h00); img.push_back(8'h00);
    for (int k = 0; k < 8; k++) img.push_back(8'(8'h30 + 3 * k));
    m_unstable = 0;
    m_force = 20;
    start_image(img);
    got = 0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(negedge clk);
      got = mem_sel_out;
    end
    chk("stall/mem_sel_seen", got, 1);
    repeat (10) @(negedge clk);
    chk("stall/stable", m_unstable, 0);
    chk("stall/still_sel", mem_sel_out, 1);
    chk("stall/no_write", mem_log.size(), 0);
    chk("stall/fields", {mem_address_out, mem_write_mask_out, mem_write_value_out},
        {MB, 4'b1111, 32'h39363330});
    #2 reset = 1'b1;
    #1;
    chk("stall/rst_mem_sel", {mem_sel_out, mem_write_mask_out, mem_address_out}, 0);
    chk("stall/rst_sel", sel_out, 0);
    m_force = 0;
    @(negedge clk);
    @(negedge clk);
    uart_log.delete(); mem_log.delete(); rxq = img;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("stall/busy", busy_out, 1);
    chk("stall/init_sel", {sel_out, read_out, address_out, write_mask_out, write_value_out},
        {1'b1, 1'b0, UB, 4'b0011, 32'h0000_0068});
    wait_end("stall");
    check_model(img, "stall");

    chk("protocol", proto_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
